// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and load-op encodings for the data-SRAM response stage
package mem_resp_pkg;

    localparam int LOAD_OP_LB  = 0;
    localparam int LOAD_OP_LBU = 1;
    localparam int LOAD_OP_LH  = 2;
    localparam int LOAD_OP_LHU = 3;
    localparam int LOAD_OP_LW  = 4;
    localparam int LOAD_OP_LWL = 5;
    localparam int LOAD_OP_LWR = 6;

    typedef logic [6:0]  load_op_t;
    typedef logic [31:0] uint32_t;
    typedef logic [31:0] virt_t;

    // One outstanding SRAM request; data holds the already-aligned load result.
    typedef struct packed {
        logic     valid;
        logic     filled;
        logic     cancel;
        load_op_t load_op;
        logic [1:0] addr_lo;
        uint32_t  rt_old;
        logic [4:0] dest;
        uint32_t  data;
    } entry_t;

endpackage

// File: rtl/mem_resp_load_align.sv
// rtl/mem_resp_load_align.sv - aligns and extends a returned SRAM word for one load op
module mem_resp_load_align
    import mem_resp_pkg::*;
(
    input  logic [6:0]  load_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_old,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = '0;
        if (load_op[LOAD_OP_LB]) begin
            data = {{24{byte_sel[7]}}, byte_sel};
        end else if (load_op[LOAD_OP_LBU]) begin
            data = {24'd0, byte_sel};
        end else if (load_op[LOAD_OP_LH]) begin
            data = {{16{half_sel[15]}}, half_sel};
        end else if (load_op[LOAD_OP_LHU]) begin
            data = {16'd0, half_sel};
        end else if (load_op[LOAD_OP_LW]) begin
            data = rdata;
        end else if (load_op[LOAD_OP_LWL]) begin
            // lwl fills the high bytes of rt with the low end of the word
            case (addr_lo)
                2'd0: data = {rdata[7:0],  rt_old[23:0]};
                2'd1: data = {rdata[15:0], rt_old[15:0]};
                2'd2: data = {rdata[23:0], rt_old[7:0]};
                default: data = rdata;
            endcase
        end else if (load_op[LOAD_OP_LWR]) begin
            case (addr_lo)
                2'd0: data = rdata;
                2'd1: data = {rt_old[31:24], rdata[31:8]};
                2'd2: data = {rt_old[31:16], rdata[31:16]};
                default: data = {rt_old[31:8], rdata[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/mem_resp.sv
// rtl/mem_resp.sv - in-order response queue for data-SRAM loads/stores with flush draining
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_load_op,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] req_rt_old,
    input  logic [4:0]  req_dest,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dest,
    output logic        idle
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    entry_t        q [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] fill;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic          stray_ok;

    logic          fill_ok;
    logic          do_fill;
    logic          do_push;
    logic          do_pop;
    logic          head_load;
    logic          head_done;
    logic [31:0]   fill_data;

    assign fill_ok   = q[fill].valid && !q[fill].filled;
    assign do_fill   = data_data_ok && fill_ok;
    assign head_load = q[head].load_op != '0;
    assign head_done = q[head].valid && q[head].filled;
    assign wb_valid  = head_done && !q[head].cancel && head_load;
    assign do_pop    = head_done && (q[head].cancel || !head_load || wb_ready);
    assign req_ready = count < FULL;
    assign do_push   = req_valid && req_ready;
    assign idle      = count == '0;
    assign wb_data   = wb_valid ? q[head].data : '0;
    assign wb_dest   = wb_valid ? q[head].dest : '0;

    // Alignment happens at fill time so the head only ever presents registered data.
    mem_resp_load_align u_align (
        .load_op (q[fill].load_op),
        .addr_lo (q[fill].addr_lo),
        .rdata   (data_rdata),
        .rt_old  (q[fill].rt_old),
        .data    (fill_data)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            count    <= '0;
            stray_ok <= 1'b1;
        end else begin
            // Responses to requests issued before a reset may still arrive until new traffic starts.
            assert (!data_data_ok || fill_ok || stray_ok);

            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q[i].valid) begin
                        q[i].cancel <= 1'b1;
                    end
                end
            end

            if (do_fill) begin
                q[fill].filled <= 1'b1;
                q[fill].data   <= fill_data;
                fill           <= fill + 1'b1;
            end

            if (do_pop) begin
                q[head].valid <= 1'b0;
                head          <= head + 1'b1;
            end

            // Tail never aliases a live entry here because pushes require req_ready.
            if (do_push) begin
                q[tail].valid   <= 1'b1;
                q[tail].filled  <= 1'b0;
                q[tail].cancel  <= 1'b0;
                q[tail].load_op <= req_load_op;
                q[tail].addr_lo <= req_addr_lo;
                q[tail].rt_old  <= req_rt_old;
                q[tail].dest    <= req_dest;
                q[tail].data    <= '0;
                tail            <= tail + 1'b1;
                stray_ok        <= 1'b0;
            end

            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_resp.sv
// tb/tb_mem_resp.sv - vector, sequence and randomized model checks for mem_resp
module tb_mem_resp;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_load_op = '0;
    logic [1:0]  req_addr_lo = '0;
    logic [31:0] req_rt_old = '0;
    logic [4:0]  req_dest = '0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        flush = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic        idle;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] OP_ST  = 7'h00;
    localparam logic [6:0] OP_LB  = 7'h01;
    localparam logic [6:0] OP_LBU = 7'h02;
    localparam logic [6:0] OP_LH  = 7'h04;
    localparam logic [6:0] OP_LHU = 7'h08;
    localparam logic [6:0] OP_LW  = 7'h10;
    localparam logic [6:0] OP_LWL = 7'h20;
    localparam logic [6:0] OP_LWR = 7'h40;

    mem_resp #(.DEPTH(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_load_op  (req_load_op),
        .req_addr_lo  (req_addr_lo),
        .req_rt_old   (req_rt_old),
        .req_dest     (req_dest),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .wb_dest      (wb_dest),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [6:0] op, input logic [1:0] a, input logic [31:0] rt, input logic [4:0] d);
        req_valid = 1'b1; req_load_op = op; req_addr_lo = a; req_rt_old = rt; req_dest = d;
    endtask

    task automatic clear_inputs();
        req_valid = 1'b0; data_data_ok = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    endtask

    function automatic logic [31:0] ref_align(input logic [6:0] op, input logic [1:0] a,
                                              input logic [31:0] r, input logic [31:0] rt);
        longint unsigned rr = 64'(r);
        longint unsigned tt = 64'(rt);
        longint unsigned res;
        int sh;
        int v;
        case (op)
            OP_LB, OP_LBU: begin
                v = int'((rr >> (8 * int'(a))) & 64'hFF);
                if (op == OP_LB && v >= 128) v -= 256;
                return 32'(v);
            end
            OP_LH, OP_LHU: begin
                v = int'((rr >> (a[1] ? 16 : 0)) & 64'hFFFF);
                if (op == OP_LH && v >= 32768) v -= 65536;
                return 32'(v);
            end
            OP_LW: return r;
            OP_LWL: begin
                sh = 8 * (3 - int'(a));
                res = ((rr << sh) & 64'hFFFF_FFFF) | (tt & ((64'd1 << sh) - 1));
                return res[31:0];
            end
            OP_LWR: begin
                sh = 8 * int'(a);
                res = (rr >> sh) | (tt & ~(64'hFFFF_FFFF >> sh) & 64'hFFFF_FFFF);
                return res[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [6:0]  op;
        logic [1:0]  a;
        logic [31:0] rdata;
        logic [31:0] rt;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [6:0]  op;
        logic [1:0]  a;
        logic [31:0] rt;
        logic [4:0]  dest;
        bit          filled;
        bit          cancel;
        logic [31:0] data;
    } mrec_t;

    vec_t  vecs[$];
    mrec_t mq[$];

    initial begin
        vecs.push_back('{OP_LB,  2'd3, 32'h80FF_1234, 32'h0,          32'hFFFF_FF80});
        vecs.push_back('{OP_LBU, 2'd3, 32'h80FF_1234, 32'h0,          32'h0000_0080});
        vecs.push_back('{OP_LWL, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hCCDD_3344});
        vecs.push_back('{OP_LWR, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_AABB});
        vecs.push_back('{OP_LWL, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'hDD22_3344});
        vecs.push_back('{OP_LWL, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'hBBCC_DD44});
        vecs.push_back('{OP_LWL, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD});
        vecs.push_back('{OP_LWR, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD});
        vecs.push_back('{OP_LWR, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h11AA_BBCC});
        vecs.push_back('{OP_LWR, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_33AA});
        vecs.push_back('{OP_LH,  2'd2, 32'h8001_7FFF, 32'h0,          32'hFFFF_8001});
        vecs.push_back('{OP_LHU, 2'd2, 32'h8001_7FFF, 32'h0,          32'h0000_8001});
        vecs.push_back('{OP_LH,  2'd0, 32'h8001_7FFF, 32'h0,          32'h0000_7FFF});
        vecs.push_back('{OP_LB,  2'd1, 32'h1234_5678, 32'h0,          32'h0000_0056});
        vecs.push_back('{OP_LB,  2'd2, 32'h12F4_5678, 32'h0,          32'hFFFF_FFF4});
        vecs.push_back('{OP_LW,  2'd0, 32'hDEAD_BEEF, 32'h0,          32'hDEAD_BEEF});

        repeat (3) tick();
        check("reset_wb_valid", 32'(wb_valid), 32'd0);
        check("reset_wb_data", wb_data, 32'd0);
        check("reset_wb_dest", 32'(wb_dest), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_idle", 32'(idle), 32'd1);
        resetn = 1'b1;
        tick();

        // Single-load alignment vectors
        for (int i = 0; i < vecs.size(); i++) begin
            push(vecs[i].op, vecs[i].a, vecs[i].rt, 5'(i + 1));
            tick();
            clear_inputs();
            check("vec_wait_valid", 32'(wb_valid), 32'd0);
            data_data_ok = 1'b1; data_rdata = vecs[i].rdata;
            tick();
            clear_inputs();
            check("vec_valid", 32'(wb_valid), 32'd1);
            check("vec_data", wb_data, vecs[i].exp);
            check("vec_dest", 32'(wb_dest), 32'(i + 1));
            wb_ready = 1'b1;
            tick();
            clear_inputs();
            check("vec_idle", 32'(idle), 32'd1);
        end

        // Back-pressure with a full queue
        push(OP_LW, 2'd0, 32'h0, 5'd4); tick();
        push(OP_LBU, 2'd1, 32'h0, 5'd5); tick();
        clear_inputs();
        check("full_req_ready", 32'(req_ready), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h0102_0304; tick();
        data_data_ok = 1'b1; data_rdata = 32'hA0B0_C0D0; tick();
        clear_inputs();
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", 32'(wb_valid), 32'd1);
            check("hold_data", wb_data, 32'h0102_0304);
            check("hold_dest", 32'(wb_dest), 32'd4);
            tick();
        end
        wb_ready = 1'b1; tick(); wb_ready = 1'b0;
        check("pop1_req_ready", 32'(req_ready), 32'd1);
        check("second_data", wb_data, 32'h0000_00C0);
        check("second_dest", 32'(wb_dest), 32'd5);
        wb_ready = 1'b1; tick(); clear_inputs();
        check("bp_idle", 32'(idle), 32'd1);

        // Store ahead of a load
        push(OP_ST, 2'd0, 32'h0, 5'd3); tick();
        push(OP_LW, 2'd0, 32'h0, 5'd7); tick();
        clear_inputs();
        data_data_ok = 1'b1; data_rdata = 32'h1111_1111; tick();
        clear_inputs();
        check("store_no_valid", 32'(wb_valid), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h7777_0007; tick();
        clear_inputs();
        check("ld_after_st_valid", 32'(wb_valid), 32'd1);
        check("ld_after_st_dest", 32'(wb_dest), 32'd7);
        check("ld_after_st_data", wb_data, 32'h7777_0007);
        wb_ready = 1'b1; tick(); clear_inputs();

        // Flush of two outstanding loads
        push(OP_LW, 2'd0, 32'h0, 5'd1); tick();
        push(OP_LW, 2'd0, 32'h0, 5'd2); tick();
        clear_inputs();
        flush = 1'b1; tick(); clear_inputs();
        data_data_ok = 1'b1; data_rdata = 32'h5; tick();
        check("flush_no_valid1", 32'(wb_valid), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h6; tick();
        clear_inputs();
        check("flush_no_valid2", 32'(wb_valid), 32'd0);
        check("flush_not_idle_yet", 32'(idle), 32'd0);
        tick();
        check("flush_idle", 32'(idle), 32'd1);
        check("flush_no_valid3", 32'(wb_valid), 32'd0);

        // Push in the flush cycle survives
        push(OP_LW, 2'd0, 32'h0, 5'd1); tick();
        push(OP_LW, 2'd0, 32'h0, 5'd9); flush = 1'b1; tick();
        clear_inputs();
        data_data_ok = 1'b1; data_rdata = 32'h1; tick();
        check("fpush_first_dropped", 32'(wb_valid), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h55; tick();
        clear_inputs();
        check("fpush_valid", 32'(wb_valid), 32'd1);
        check("fpush_dest", 32'(wb_dest), 32'd9);
        check("fpush_data", wb_data, 32'h55);
        wb_ready = 1'b1; tick(); clear_inputs();

        // Reset mid-stream, then a stray response
        push(OP_LW, 2'd0, 32'h0, 5'd1); tick();
        push(OP_LW, 2'd0, 32'h0, 5'd2); tick();
        clear_inputs();
        data_data_ok = 1'b1; data_rdata = 32'h9; tick();
        data_data_ok = 1'b1; data_rdata = 32'hA; tick();
        clear_inputs();
        resetn = 1'b0; tick(); resetn = 1'b1;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);
        data_data_ok = 1'b1; data_rdata = 32'hBAD; tick();
        clear_inputs();
        check("stray_no_valid", 32'(wb_valid), 32'd0);
        check("stray_idle", 32'(idle), 32'd1);
        tick();
        check("stray_no_valid2", 32'(wb_valid), 32'd0);

        // Randomized traffic against a queue model
        begin
            logic [6:0] ops [8] = '{OP_ST, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
            for (int cyc = 0; cyc < 600; cyc++) begin
                bit          exp_v;
                bit          do_push, do_ok, do_fl, do_rdy, do_pop;
                int          fidx;
                mrec_t       nr;
                logic [31:0] rd;

                exp_v = mq.size() > 0 && mq[0].filled && !mq[0].cancel && mq[0].op != OP_ST;
                check("rnd_wb_valid", 32'(wb_valid), 32'(exp_v));
                check("rnd_req_ready", 32'(req_ready), 32'(mq.size() < 2));
                check("rnd_idle", 32'(idle), 32'(mq.size() == 0));
                if (exp_v) begin
                    check("rnd_wb_data", wb_data, mq[0].data);
                    check("rnd_wb_dest", 32'(wb_dest), 32'(mq[0].dest));
                end

                fidx = -1;
                for (int k = 0; k < mq.size(); k++) begin
                    if (!mq[k].filled && fidx < 0) fidx = k;
                end
                do_push = mq.size() < 2 && ($urandom_range(0, 1) == 1);
                do_ok   = fidx >= 0 && ($urandom_range(0, 2) != 0);
                do_fl   = $urandom_range(0, 15) == 0;
                do_rdy  = $urandom_range(0, 2) != 0;
                rd      = $urandom;
                nr.op = ops[$urandom_range(0, 7)];
                nr.a  = 2'($urandom_range(0, 3));
                nr.rt = $urandom;
                nr.dest = 5'($urandom_range(0, 31));
                nr.filled = 0; nr.cancel = 0; nr.data = '0;

                req_valid = do_push; req_load_op = nr.op; req_addr_lo = nr.a;
                req_rt_old = nr.rt; req_dest = nr.dest;
                data_data_ok = do_ok; data_rdata = rd;
                flush = do_fl; wb_ready = do_rdy;
                tick();
                clear_inputs();

                do_pop = mq.size() > 0 && mq[0].filled &&
                         (mq[0].cancel || mq[0].op == OP_ST || do_rdy);
                if (do_ok) begin
                    mq[fidx].filled = 1;
                    mq[fidx].data = ref_align(mq[fidx].op, mq[fidx].a, rd, mq[fidx].rt);
                end
                if (do_fl) begin
                    for (int k = 0; k < mq.size(); k++) mq[k].cancel = 1;
                end
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(nr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Response half of the data-SRAM interface; pairs with the request stage that drives data_wr/data_size/data_wstrb/data_vaddr.
- Tracks loads and stores accepted by the SRAM in issue order and captures data_ok/rdata, which cannot be stalled.
- Aligns and extends load data (lb/lbu/lh/lhu/lw/lwl/lwr, including the lwl/lwr merge with the old rt value) and hands results to writeback over a valid/ready handshake.
- Supports pipeline flush by silently draining responses for cancelled requests.

Parameters:
- DEPTH, 2, maximum outstanding requests (power of two, at least 2).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  1  request accepted by SRAM this cycle (req & addr_ok). Only asserted when req_ready is high.
- req_ready  out  1  queue not full (count < DEPTH).
- req_load_op  in  7  one-hot {lwr,lwl,lw,lhu,lh,lbu,lb}, bits 6..0. Zero means store.
- req_addr_lo  in  2  original (unaligned) mem_addr[1:0].
- req_rt_old  in  32  current rt value, used by lwl/lwr.
- req_dest  in  5  destination GPR.
- data_data_ok  in  1  response strobe; in order; cannot be back-pressured.
- data_rdata  in  32  full aligned word at the word address.
- flush  in  1  cancel every entry present before this edge.
- wb_valid  out  1  aligned load result available.
- wb_ready  in  1  writeback accepts.
- wb_data  out  32  aligned/extended result.
- wb_dest  out  5  destination register.
- idle  out  1  queue empty.

Behaviour:
- Reset (resetn low at a clk edge):
  - All entries invalid; head, fill and tail pointers = 0; count = 0.
  - wb_valid = 0, wb_data = 0, wb_dest = 0, req_ready = 1, idle = 1.
  - Reset mid-transaction drops all state; any later stray data_ok is ignored.
- Entry fields: valid, filled, cancel, load_op, addr_lo, rt_old, dest, rdata.
- Push: req_valid writes the entry at tail with filled = 0, cancel = 0; tail++.
- Fill: data_data_ok writes data_rdata into the oldest unfilled valid entry (fill pointer) and sets filled; fill++.
  - data_ok with no unfilled entry is a protocol error: ignored, with an assertion in simulation.
- Head outputs:
  - wb_valid = head.valid & head.filled & !head.cancel & (load_op != 0).
  - wb_data = align(head), registered in the entry, not combinational from data_rdata.
  - Latency: data_ok at edge t gives wb_valid high after edge t (visible in cycle t+1).
- Pop:
  - Load, not cancelled: pops when wb_valid & wb_ready.
  - Store, or any cancelled entry: pops silently as soon as filled (one per cycle).
  - wb_valid is held, with wb_data/wb_dest stable, until wb_ready.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged; allowed only when req_ready was 1.
  - Fill and pop of the same entry in the same cycle is impossible, because pop requires filled already registered.
- Flush: sets cancel on all valid entries. A push in the same cycle is not cancelled (upstream suppresses killed requests). wb_valid drops the cycle after flush.
- Alignment, a = addr_lo, r = rdata:
  - lb: sign-extend r byte a. lbu: zero-extend the same byte.
  - lh/lhu: sign- or zero-extend r[31:16] if a[1], else r[15:0].
  - lw: r.
  - lwl, a = 0/1/2/3: {r[7:0],rt[23:0]}, {r[15:0],rt[15:0]}, {r[23:0],rt[7:0]}, r.
  - lwr, a = 0/1/2/3: r, {rt[31:24],r[31:8]}, {rt[31:16],r[31:16]}, {rt[31:8],r[31:24]}.
- Wrap-around: pointers are log2(DEPTH) bits wide and wrap naturally; count is a separate counter of log2(DEPTH)+1 bits.

Decomposition:
- Shared header cpu.svh:
  - LOAD_OP_LB..LOAD_OP_LWR bit-index constants (0..6).
  - load_op_t as logic [6:0].
  - Existing virt_t / uint32_t.
- Sub-module load_align: combinational (load_op, addr_lo, rdata, rt_old) -> data. The request stage's store-side lane logic is its mirror.

Test Plan:
- lb at a=3, rdata 0x80FF_1234 -> wb_data 0xFFFF_FF80, wb_valid 1 cycle after data_ok; lbu at the same address -> 0x0000_0080.
- lwl a=1, rt 0x1122_3344, rdata 0xAABB_CCDD -> 0xCCDD_3344; lwr a=2 with the same rt/rdata -> 0x1122_AABB.
- Push 2 loads back-to-back (DEPTH=2) -> req_ready 0. Two data_oks with wb_ready held 0 for 5 cycles -> both results retained and emitted in order; req_ready returns 1 after the first pop.
- Store then load outstanding, then responses -> store ack pops silently with no wb_valid; the load emits next with the correct dest.
- Two loads outstanding, flush asserted, then two data_oks -> no wb_valid; idle = 1 two cycles after the last data_ok; a new load pushed in the flush cycle is emitted normally.
- resetn low mid-stream with 2 entries filled -> next cycle wb_valid 0, req_ready 1, idle 1; a later stray data_ok triggers no output.
